// File: rtl/ram_arb_ctrl.sv
// Round-robin arbiter/sequencer between two masters and one 128x32 sync RAM.
// Optional post-reset zero sweep of the RAM is enabled with `define MEM_INIT_EN.
module ram_arb_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  init_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    logic                  r_prio;
    logic                  r_rvalid_a;
    logic                  r_rvalid_b;
    logic                  r_init_done;
    logic                  w_run;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_sweep;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;

`ifdef MEM_INIT_EN
    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sweep;

    // Sweep stops at the last address; RUN is entered on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_init_done <= 1'b0;
        end else begin
            unique case (r_state)
                S_INIT: begin
                    if (r_sweep == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep <= r_sweep + ADDR_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    assign w_sweep      = (r_state == S_INIT) && !reset;
    assign w_sweep_addr = r_sweep;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_done <= 1'b1;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    assign w_sweep      = 1'b0;
    assign w_sweep_addr = '0;
`endif

    assign w_run   = r_init_done && !reset;
    assign w_gnt_a = w_run && req_a && (!req_b || !r_prio);
    assign w_gnt_b = w_run && req_b && (!req_a || r_prio);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio     <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            if (w_gnt_a) begin
                r_prio <= 1'b1;
            end else if (w_gnt_b) begin
                r_prio <= 1'b0;
            end
            r_rvalid_a <= w_gnt_a && !we_a;
            r_rvalid_b <= w_gnt_b && !we_b;
        end
    end

    // A read accepted just before reset must not surface while reset is high.
    assign rvalid_a  = r_rvalid_a && !reset;
    assign rvalid_b  = r_rvalid_b && !reset;
    assign rdata_a   = mem_q;
    assign rdata_b   = mem_q;
    assign gnt_a     = w_gnt_a;
    assign gnt_b     = w_gnt_b;
    assign init_done = r_init_done;

    always_comb begin
        mem_we      = (w_gnt_a && we_a) || (w_gnt_b && we_b);
        mem_address = w_gnt_b ? addr_b : addr_a;
        mem_d       = w_gnt_b ? wdata_b : wdata_a;
        if (w_sweep) begin
            mem_we      = 1'b1;
            mem_address = w_sweep_addr;
            mem_d       = '0;
        end
    end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl with a behavioural 128x32 synchronous RAM.
// Covers the MEM_INIT_EN sweep when that macro is defined for the build.
module tb_ram_arb_ctrl;

    logic        clk;
    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [6:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, init_done, mem_we;
    logic [31:0] rdata_a, rdata_b, mem_d, mem_q;
    logic [6:0]  mem_address;
    logic [31:0] ram [128];

    int n_chk  = 0;
    int n_pass = 0;

`ifdef MEM_INIT_EN
    localparam logic INIT_RST = 1'b0;
    localparam logic [31:0] RD1_AFTER_RST = 32'h0;
`else
    localparam logic INIT_RST = 1'b1;
    localparam logic [31:0] RD1_AFTER_RST = 32'h11111111;
`endif

    ram_arb_ctrl dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .init_done(init_done),
        .mem_we(mem_we), .mem_address(mem_address), .mem_d(mem_d),
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we) ram[mem_address] <= mem_d;
        mem_q <= ram[mem_address];
    end

    typedef struct {
        logic        ra, wa;
        logic [6:0]  aa;
        logic [31:0] da;
        logic        rb, wb;
        logic [6:0]  ab;
        logic [31:0] db;
        logic        ga, gb, mwe, va, vb;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(int ra, int wa, int aa, logic [31:0] da,
                                int rb, int wb, int ab, logic [31:0] db,
                                int ga, int gb, int mwe, int va, int vb,
                                logic [31:0] rd);
        vec_t v;
        v.ra = ra[0]; v.wa = wa[0]; v.aa = 7'(aa); v.da = da;
        v.rb = rb[0]; v.wb = wb[0]; v.ab = 7'(ab); v.db = db;
        v.ga = ga[0]; v.gb = gb[0]; v.mwe = mwe[0];
        v.va = va[0]; v.vb = vb[0]; v.rd = rd;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 300 && !init_done; i++) tick();
        chk1("init_done_wait", init_done, 1'b1);
    endtask

    task automatic idle();
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    endtask

    initial begin
        tv[0]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,          1,0,1, 0,0, 0);
        tv[1]  = mk(1,0,5,0,            0,0,0,0,          1,0,0, 0,0, 0);
        tv[2]  = mk(0,1,9,32'h0BADF00D, 0,1,9,32'h0BAD,   0,0,0, 1,0, 32'hDEADBEEF);
        tv[3]  = mk(1,1,1,32'h11111111, 0,0,0,0,          1,0,1, 0,0, 0);
        tv[4]  = mk(0,0,0,0,            1,1,2,32'h22222222, 0,1,1, 0,0, 0);
        tv[5]  = mk(1,0,1,0,            1,0,2,0,          1,0,0, 0,0, 0);
        tv[6]  = mk(1,0,1,0,            1,0,2,0,          0,1,0, 1,0, 32'h11111111);
        tv[7]  = mk(1,0,1,0,            1,0,2,0,          1,0,0, 0,1, 32'h22222222);
        tv[8]  = mk(1,0,1,0,            1,0,2,0,          0,1,0, 1,0, 32'h11111111);
        tv[9]  = mk(1,0,1,0,            1,0,2,0,          1,0,0, 0,1, 32'h22222222);
        tv[10] = mk(1,0,1,0,            1,0,2,0,          0,1,0, 1,0, 32'h11111111);
        tv[11] = mk(0,1,64,32'hFFFF,    1,1,127,32'h12345678, 0,1,1, 0,1, 32'h22222222);
        tv[12] = mk(1,0,127,0,          0,0,0,0,          1,0,0, 0,0, 0);
        tv[13] = mk(0,0,0,0,            0,0,0,0,          0,0,0, 1,0, 32'h12345678);
        tv[14] = mk(1,0,1,0,            0,0,0,0,          1,0,0, 0,0, 0);
        tv[15] = mk(1,0,1,0,            1,0,2,0,          0,1,0, 1,0, 32'h11111111);
        tv[16] = mk(1,0,1,0,            0,0,0,0,          1,0,0, 0,1, 32'h22222222);
        tv[17] = mk(1,1,3,32'hCAFEF00D, 0,0,0,0,          1,0,1, 1,0, 32'h11111111);
        tv[18] = mk(0,0,0,0,            1,0,3,0,          0,1,0, 0,0, 0);
        tv[19] = mk(0,0,0,0,            0,0,0,0,          0,0,0, 0,1, 32'hCAFEF00D);

        idle();
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        tick();
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_gnt_b", gnt_b, 1'b0);
        chk1("rst_rvalid_a", rvalid_a, 1'b0);
        chk1("rst_rvalid_b", rvalid_b, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_init_done", init_done, INIT_RST);
        reset = 1'b0;
        idle();
        wait_init();

        for (int i = 0; i < 20; i++) begin
            tick();
            chk1($sformatf("v%0d_rvalid_a", i), rvalid_a, tv[i].va);
            chk1($sformatf("v%0d_rvalid_b", i), rvalid_b, tv[i].vb);
            if (tv[i].va) chk32($sformatf("v%0d_rdata_a", i), rdata_a, tv[i].rd);
            if (tv[i].vb) chk32($sformatf("v%0d_rdata_b", i), rdata_b, tv[i].rd);
            req_a = tv[i].ra; we_a = tv[i].wa; addr_a = tv[i].aa; wdata_a = tv[i].da;
            req_b = tv[i].rb; we_b = tv[i].wb; addr_b = tv[i].ab; wdata_b = tv[i].db;
            #2;
            chk1($sformatf("v%0d_gnt_a", i), gnt_a, tv[i].ga);
            chk1($sformatf("v%0d_gnt_b", i), gnt_b, tv[i].gb);
            chk1($sformatf("v%0d_mem_we", i), mem_we, tv[i].mwe);
            if (tv[i].ga || tv[i].gb)
                chk32($sformatf("v%0d_mem_address", i), 32'(mem_address),
                      32'(tv[i].gb ? tv[i].ab : tv[i].aa));
            if (tv[i].mwe)
                chk32($sformatf("v%0d_mem_d", i), mem_d, tv[i].gb ? tv[i].db : tv[i].da);
        end

        // read accepted, then reset in the following cycle
        tick();
        idle();
        req_a = 1'b1; addr_a = 7'd1;
        #2;
        chk1("mid_rd_gnt_a", gnt_a, 1'b1);
        tick();
        reset = 1'b1;
        req_b = 1'b1; addr_b = 7'd2;
        #2;
        chk1("mid_rst_rvalid_a", rvalid_a, 1'b0);
        chk1("mid_rst_gnt_a", gnt_a, 1'b0);
        chk1("mid_rst_gnt_b", gnt_b, 1'b0);
        tick();
        reset = 1'b0;
        wait_init();
        #2;
        chk1("prio_rst_gnt_a", gnt_a, 1'b1);
        chk1("prio_rst_gnt_b", gnt_b, 1'b0);
        tick();
        chk1("prio_rst_rvalid_a", rvalid_a, 1'b1);
        chk32("prio_rst_rdata_a", rdata_a, RD1_AFTER_RST);
        idle();

`ifdef MEM_INIT_EN
        tick();
        req_a = 1'b1; we_a = 1'b1; addr_a = 7'd9; wdata_a = 32'hFFFFFFFF;
        tick();
        we_a = 1'b0;
        tick();
        chk32("prefill_rdata", rdata_a, 32'hFFFFFFFF);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 128; i++) begin
            chk1($sformatf("sw%0d_we", i), mem_we, 1'b1);
            chk32($sformatf("sw%0d_addr", i), 32'(mem_address), 32'(i));
            chk32($sformatf("sw%0d_d", i), mem_d, 32'h0);
            chk1($sformatf("sw%0d_gnt_a", i), gnt_a, 1'b0);
            chk1($sformatf("sw%0d_init", i), init_done, 1'b0);
            tick();
        end
        chk1("sweep_init_done", init_done, 1'b1);
        #2;
        chk1("sweep_gnt_a", gnt_a, 1'b1);
        tick();
        chk1("sweep_rvalid_a", rvalid_a, 1'b1);
        chk32("sweep_rdata_a", rdata_a, 32'h0);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        chk32("sw60_addr", 32'(mem_address), 32'd60);
        reset = 1'b1;
        #2;
        chk1("sw60_rst_we", mem_we, 1'b0);
        tick();
        reset = 1'b0;
        chk32("sw_restart_addr", 32'(mem_address), 32'd0);
        chk1("sw_restart_we", mem_we, 1'b1);
        wait_init();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    always @(negedge clk) begin
        if (gnt_a && gnt_b) begin
            n_chk++;
            $display("FAIL both_gnt: got gnt_a=1 gnt_b=1 expected at most one");
        end
    end

endmodule

// File: doc/ram_arb_ctrl.md
# ram_arb_ctrl

Two-requester round-robin arbiter and sequencer for the single-port synchronous 128x32 RAM. It takes read/write requests from two independent masters (A and B), grants at most one per cycle onto the RAM port, and returns read data one cycle later with a valid strobe. It optionally sweeps the RAM to zero after reset. It sits directly between the masters and the RAM instance and is the only driver of the RAM port.

## Interface
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 7, address width; RAM depth is 2**ADDR_WIDTH.

- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- req_a / req_b  input  1  request from master A / B; held until granted
- we_a / we_b  input  1  1 = write, 0 = read; qualified by req
- addr_a / addr_b  input  ADDR_WIDTH  request address
- wdata_a / wdata_b  input  DATA_WIDTH  write data
- gnt_a / gnt_b  output  1  combinational grant; request accepted in the cycle where req and gnt are both high
- rvalid_a / rvalid_b  output  1  registered; read data valid for that master
- rdata_a / rdata_b  output  DATA_WIDTH  read data; equals mem_q and is meaningful only while the matching rvalid is high
- init_done  output  1  registered; high once the block accepts requests
- mem_we  output  1  to RAM we
- mem_address  output  ADDR_WIDTH  to RAM address
- mem_d  output  DATA_WIDTH  to RAM d
- mem_q  input  DATA_WIDTH  from RAM q; registered output, valid 1 cycle after address

## Operation
- States: INIT (sweep, only with macro) and RUN. Reset enters INIT if the macro is defined, otherwise RUN.
- RUN, grant rule, with priority pointer prio (0 = A, 1 = B; reset 0):
  - Only one master requesting: that master is granted.
  - Both requesting: the master selected by prio is granted.
  - Neither requesting: no grant, mem_we=0.
- prio update: after any grant, prio points to the non-granted master. With only A requesting continuously, A is granted every cycle.
- RAM port: mux of the granted master's we/addr/wdata. With no grant, mem_we=0 and mem_address/mem_d hold the A inputs (don't-care values, never a write).
- Reads: an accepted read in cycle N sets rvalid of that master in cycle N+1, with rdata = mem_q = RAM contents at the edge ending cycle N.
- Writes: produce no rvalid. Data is in the RAM after the edge ending the accept cycle.
- A write in cycle N followed by a read of the same address in cycle N+1, from either master, returns the new data.
- The RAM's read-during-write (old data on q) never reaches a master, because writes raise no rvalid.
- gnt_a and gnt_b are never high together. Both are 0 while reset is high and while init_done=0.

## Timing
- Reset values:
  - gnt_a = gnt_b = 0.
  - rvalid_a = rvalid_b = 0.
  - prio = 0.
  - mem_we = 0.
  - init_done = 0 with the macro, 1 without it.
- Grant latency 0 cycles (combinational from req). Read latency 1 cycle from accept to rvalid.
- Throughput 1 access per cycle, aggregate across both masters.
- A read accepted in the last cycle before reset asserts: no rvalid is produced. rvalid is cleared by reset.
- A master may change addr/we/wdata freely while not granted. Values are sampled only in the accept cycle.

## Configuration
- MEM_INIT_EN defined:
  - After reset deasserts, INIT runs for 2**ADDR_WIDTH cycles: mem_we=1, mem_d=0, mem_address counts 0 to 2**ADDR_WIDTH-1 (7-bit counter, no wrap past the last address).
  - gnt_a/gnt_b are forced 0 during INIT, and requests are held off.
  - init_done rises on the cycle after the write to the last address, and the state becomes RUN.
  - Reset during INIT restarts the sweep at address 0.
- MEM_INIT_EN undefined:
  - No INIT state and no sweep counter.
  - RAM contents are undefined until written.
  - init_done=1 from the first cycle after reset, and grants begin that cycle.

## Test plan
- Single master:
  - Stimulus: A writes 0xDEADBEEF to address 5 in cycle N, then A reads address 5 in cycle N+1.
  - Response: rvalid_a=1 in cycle N+2 with rdata_a=0xDEADBEEF; rvalid_b stays 0.
- Contention:
  - Stimulus: req_a and req_b held high for 6 cycles after reset, both reading addresses 1 and 2.
  - Response: grants alternate A,B,A,B,A,B; gnt_a and gnt_b are never both high; each rvalid matches its own grant one cycle later.
- Cross-master coherency:
  - Stimulus: B writes 0x12345678 to address 127, then A reads address 127 in the next cycle.
  - Response: rdata_a=0x12345678 with rvalid_a=1.
- Fairness:
  - Stimulus: A requests continuously; B raises req_b for one cycle while prio=1.
  - Response: B is granted that cycle, and A is granted in the following cycle.
- MEM_INIT_EN sweep:
  - Stimulus: pre-fill address 9 with 0xFFFFFFFF, then reset; assert req_a during INIT.
  - Response: 128 consecutive mem_we=1 cycles with addresses 0..127; gnt_a=0 throughout; init_done rises 128 cycles after reset release; a read of address 9 returns 0.
- Reset mid-operation:
  - Stimulus: assert reset in the cycle after A's read is accepted, and separately at sweep address 60.
  - Response: no rvalid_a for the interrupted read; prio=0; the sweep restarts at address 0.
